// File: rtl/store_data_fetch.sv
// Store-data fetch stage: reads store data from the RF (or an immediate tag),
// aligns it to its byte lane and writes it into the store queue.
package store_data_fetch_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 7;
  localparam int SQN_W = 6;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [SQN_W-1:0] storeSqN;
    logic [1:0]       offs;
  } StDataLookupUOp;

  typedef struct packed {
    logic             taken;
    logic             flush;
    logic [SQN_W-1:0] storeSqN;
  } BranchProv;

  typedef struct packed {
    logic             valid;
    logic [SQN_W-1:0] storeSqN;
    logic [XLEN-1:0]  data;
  } SqWrite;
endpackage

module store_data_fetch
  import store_data_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  StDataLookupUOp   IN_uop,
  output logic             OUT_ready,
  input  BranchProv        IN_branch,
  output logic             OUT_rfReadValid,
  output logic [TAG_W-2:0] OUT_rfReadAddr,
  input  logic             IN_rfReadGrant,
  input  logic [XLEN-1:0]  IN_rfReadData,
  output SqWrite           OUT_sqWrite
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SQN_W-1:0] sqn;
    logic [1:0]       offs;
  } stage_t;

  // vld_pipe[0]=stA, [1]=stB, [2]=store-queue write
  logic [STAGES:0]  vld_pipe;
  stage_t           st_a, st_b;
  logic [SQN_W-1:0] out_sqn;
  logic [XLEN-1:0]  out_data;

  logic             a_imm, a_adv, kill_in, kill_a, kill_b;
  logic [XLEN-1:0]  raw, shifted;

  // Younger-than-branch test on wrap-around sequence numbers: difference > 0.
  function automatic logic killed(input logic [SQN_W-1:0] sqn, input BranchProv br);
    logic [SQN_W-1:0] d;
    d = sqn - br.storeSqN;
    return br.taken && (br.flush || (!d[SQN_W-1] && (d != '0)));
  endfunction

  always_comb begin
    a_imm   = st_a.tag[TAG_W-1];
    a_adv   = !vld_pipe[0] || a_imm || IN_rfReadGrant;
    kill_in = killed(IN_uop.storeSqN, IN_branch);
    kill_a  = killed(st_a.sqn, IN_branch);
    kill_b  = killed(st_b.sqn, IN_branch);

    OUT_ready       = a_adv;
    OUT_rfReadValid = vld_pipe[0] && !a_imm;
    OUT_rfReadAddr  = st_a.tag[TAG_W-2:0];

    // RF data lands in the cycle stB holds the entry (write-first RF)
    raw     = st_b.tag[TAG_W-1] ? {{(XLEN-TAG_W+1){1'b0}}, st_b.tag[TAG_W-2:0]}
                                : IN_rfReadData;
    shifted = raw << {st_b.offs, 3'b000};

    OUT_sqWrite          = '0;
    OUT_sqWrite.valid    = vld_pipe[STAGES];
    OUT_sqWrite.storeSqN = out_sqn;
    OUT_sqWrite.data     = out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      st_a     <= '0;
      st_b     <= '0;
      out_sqn  <= '0;
      out_data <= '0;
    end else begin
      if (a_adv) begin
        st_a        <= '{tag: IN_uop.tag, sqn: IN_uop.storeSqN, offs: IN_uop.offs};
        vld_pipe[0] <= IN_uop.valid && !kill_in;
        st_b        <= st_a;
        // kill wins over grant: an already-issued read is simply ignored
        vld_pipe[1] <= vld_pipe[0] && !kill_a;
      end else begin
        vld_pipe[0] <= vld_pipe[0] && !kill_a;
        vld_pipe[1] <= 1'b0;
      end
      vld_pipe[2] <= vld_pipe[1] && !kill_b;
      out_sqn     <= st_b.sqn;
      out_data    <= shifted;
    end
  end
endmodule

// File: tb/tb_store_data_fetch.sv
// Scoreboard bench for store_data_fetch: expected writes queued at drive time,
// popped by a monitor on OUT_sqWrite.
module tb_store_data_fetch;
  import store_data_fetch_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  StDataLookupUOp   in_uop;
  BranchProv        branch;
  logic             ready, rf_valid, grant;
  logic [TAG_W-2:0] rf_addr;
  logic [XLEN-1:0]  rf_data;
  SqWrite           sq_write;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [SQN_W-1:0] sqn;
    logic [XLEN-1:0]  data;
  } exp_t;
  exp_t sb[$];

  store_data_fetch dut (
    .clk(clk), .rst(rst), .IN_uop(in_uop), .OUT_ready(ready), .IN_branch(branch),
    .OUT_rfReadValid(rf_valid), .OUT_rfReadAddr(rf_addr), .IN_rfReadGrant(grant),
    .IN_rfReadData(rf_data), .OUT_sqWrite(sq_write)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sq_write.valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write sqn=%h data=%h", sq_write.storeSqN, sq_write.data);
      end else begin
        e = sb.pop_front();
        if (sq_write.storeSqN !== e.sqn || sq_write.data !== e.data) begin
          fails++;
          $display("FAIL sq_write got sqn=%h data=%h want sqn=%h data=%h",
                   sq_write.storeSqN, sq_write.data, e.sqn, e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic [TAG_W-1:0] tag,
                     input logic [SQN_W-1:0] sqn, input logic [1:0] offs);
    in_uop.valid = v; in_uop.tag = tag; in_uop.storeSqN = sqn; in_uop.offs = offs;
  endtask

  task automatic expect_wr(input logic [SQN_W-1:0] sqn, input logic [XLEN-1:0] data);
    exp_t e;
    e.sqn = sqn; e.data = data;
    sb.push_back(e);
  endtask

  task automatic chk_wr_valid(input string name, input logic want);
    tests++;
    if (sq_write.valid !== want) begin
      fails++;
      $display("FAIL %s sq_write.valid got %b want %b", name, sq_write.valid, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; grant = 1'b0; rf_data = '0; branch = '0; put(0, 0, 0, 0);
    step(); #1;
    tests++;
    if (ready !== 1'b1 || rf_valid !== 1'b0 || sq_write.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset ready=%b rf_valid=%b wr=%b want 1 0 0", ready, rf_valid, sq_write.valid);
    end
    rst = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    grant = 1'b1; rf_data = 32'hAABBCCDD;
    put(1, 7'd5, 6'h01, 2'd0); expect_wr(6'h01, 32'hAABBCCDD);
    step();
    put(1, 7'd6, 6'h02, 2'd1); expect_wr(6'h02, 32'hBBCCDD00);
    #1;
    tests++;
    if (rf_valid !== 1'b1 || rf_addr !== 6'd5) begin
      fails++;
      $display("FAIL b2b_req rf_valid=%b addr=%h want 1 05", rf_valid, rf_addr);
    end
    step();
    put(1, 7'd7, 6'h03, 2'd3); expect_wr(6'h03, 32'hDD000000);
    chk_wr_valid("b2b_lat_n1", 1'b0);
    step(); put(0, 0, 0, 0);
    chk_wr_valid("b2b_n2", 1'b1);
    step(); chk_wr_valid("b2b_n3", 1'b1);
    step(); chk_wr_valid("b2b_n4", 1'b1);
    step(); chk_wr_valid("b2b_drain", 1'b0);
  endtask

  task automatic test_immediate();
    grant = 1'b0; rf_data = 32'hFFFFFFFF;
    put(1, 7'h41, 6'h04, 2'd0); expect_wr(6'h04, 32'h00000001);
    step();
    put(1, 7'h7F, 6'h05, 2'd2); expect_wr(6'h05, 32'h003F0000);
    #1;
    tests++;
    if (rf_valid !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL imm_noreq rf_valid=%b ready=%b want 0 1", rf_valid, ready);
    end
    step(); put(0, 0, 0, 0);
    chk_wr_valid("imm_lat_n1", 1'b0);
    step(); chk_wr_valid("imm_n2", 1'b1);
    step(); chk_wr_valid("imm_n3", 1'b1);
    step(); chk_wr_valid("imm_drain", 1'b0);
  endtask

  task automatic test_grant_denied();
    grant = 1'b0; rf_data = 32'h12345678;
    put(1, 7'h0A, 6'h06, 2'd2); expect_wr(6'h06, 32'h56780000);
    step();
    put(1, 7'h0B, 6'h07, 2'd0); expect_wr(6'h07, 32'h12345678);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) grant = 1'b1;
      #1;
      tests++;
      if (rf_valid !== 1'b1 || rf_addr !== 6'h0A || ready !== (i == 4)) begin
        fails++;
        $display("FAIL denied_c%0d rf_valid=%b addr=%h ready=%b want 1 0a %b",
                 i, rf_valid, rf_addr, ready, (i == 4));
      end
      chk_wr_valid("denied_nowr", 1'b0);
      step();
    end
    put(0, 0, 0, 0);
    #1;
    tests++;
    if (rf_valid !== 1'b1 || rf_addr !== 6'h0B) begin
      fails++;
      $display("FAIL denied_second rf_valid=%b addr=%h want 1 0b", rf_valid, rf_addr);
    end
    chk_wr_valid("denied_n4", 1'b0);
    step(); chk_wr_valid("denied_n5", 1'b1);
    step(); chk_wr_valid("denied_n6", 1'b1);
    step(); chk_wr_valid("denied_drain", 1'b0);
  endtask

  task automatic test_branch_partial();
    grant = 1'b1; rf_data = 32'hCAFEF00D;
    put(1, 7'd3, 6'h10, 2'd0); expect_wr(6'h10, 32'hCAFEF00D);
    step();
    put(1, 7'd4, 6'h12, 2'd0);
    step();
    put(1, 7'd8, 6'h13, 2'd0);
    branch.taken = 1'b1; branch.flush = 1'b0; branch.storeSqN = 6'h11;
    step();
    branch = '0;
    put(1, 7'd9, 6'h11, 2'd1); expect_wr(6'h11, 32'hFEF00D00);
    #1;
    tests++;
    if (rf_valid !== 1'b0) begin
      fails++;
      $display("FAIL br_killed_uop rf_valid=%b want 0", rf_valid);
    end
    chk_wr_valid("br_survivor", 1'b1);
    step(); put(0, 0, 0, 0);
    #1;
    tests++;
    if (rf_valid !== 1'b1 || rf_addr !== 6'd9) begin
      fails++;
      $display("FAIL br_next_accept rf_valid=%b addr=%h want 1 09", rf_valid, rf_addr);
    end
    chk_wr_valid("br_dropped", 1'b0);
    step(); chk_wr_valid("br_gap", 1'b0);
    step(); chk_wr_valid("br_next_wr", 1'b1);
    step();
  endtask

  task automatic test_wrap_flush();
    grant = 1'b1; rf_data = 32'h0BADBEEF;
    put(1, 7'd2, 6'h01, 2'd0);
    step(); put(0, 0, 0, 0);
    branch.taken = 1'b1; branch.flush = 1'b0; branch.storeSqN = 6'h3F;
    step(); branch = '0;
    step(); chk_wr_valid("wrap_killed", 1'b0);
    step(); chk_wr_valid("wrap_killed2", 1'b0);
    put(1, 7'd1, 6'h20, 2'd0); expect_wr(6'h20, 32'h0BADBEEF);
    step(); put(1, 7'h42, 6'h21, 2'd0);
    step(); put(1, 7'd3, 6'h22, 2'd0);
    step(); put(0, 0, 0, 0);
    branch.taken = 1'b1; branch.flush = 1'b1; branch.storeSqN = 6'h30;
    chk_wr_valid("flush_pre", 1'b1);
    step(); branch = '0;
    #1;
    tests++;
    if (rf_valid !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_stA rf_valid=%b ready=%b want 0 1", rf_valid, ready);
    end
    chk_wr_valid("flush_post1", 1'b0);
    step(); chk_wr_valid("flush_post2", 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    grant = 1'b1; rf_data = 32'h11223344;
    put(1, 7'd1, 6'h30, 2'd0); expect_wr(6'h30, 32'h11223344);
    step(); put(1, 7'd2, 6'h31, 2'd0);
    step(); put(1, 7'd3, 6'h32, 2'd0);
    step(); put(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (sq_write.valid !== 1'b0 || rf_valid !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid wr=%b rf_valid=%b ready=%b want 0 0 1",
               sq_write.valid, rf_valid, ready);
    end
    step(); rst = 1'b0;
    step(); chk_wr_valid("reset_mid_after", 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_immediate();
    test_grant_denied();
    test_branch_partial();
    test_wrap_flush();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_data_fetch.md
# store_data_fetch

Pipeline stage directly downstream of the store-data issue queue. It accepts store-data lookup uops (tag, storeSqN, byte offset), reads the data operand from a shared register-file read port, or synthesises it from an immediate tag, and shifts it into byte-lane position. It then writes the result into the store queue entry selected by storeSqN. It applies branch flushes at every stage and backpressures the issue queue only when the register-file read port is not granted.

## Interface
- XLEN, 32: data width.
- TAG_W, 7: tag width; MSB set marks an immediate tag.
- SQN_W, 6: store sequence number width; comparisons are wrap-around signed.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- IN_uop  in  StDataLookupUOp  {valid, tag[TAG_W], storeSqN[SQN_W], offs[2]} from issue queue.
- OUT_ready  out  1  uop accepted this cycle when IN_uop.valid && OUT_ready (combinational).
- IN_branch  in  BranchProv  uses {taken, flush, storeSqN}.
- OUT_rfReadValid  out  1  register-file read request.
- OUT_rfReadAddr  out  TAG_W-1  physical register index (tag low bits).
- IN_rfReadGrant  in  1  arbiter grant for this cycle's request.
- IN_rfReadData  in  XLEN  data; valid the cycle after a granted request (write-first RF).
- OUT_sqWrite  out  {valid, storeSqN[SQN_W], data[XLEN]}  registered store-queue data write; no backpressure.

## Operation
- Three registers: stA (read request), stB (data return), out (OUT_sqWrite). Each carries valid, tag, storeSqN, offs.
- Accept: when IN_uop.valid && OUT_ready && !killed(IN_uop), load stA at the edge.
- OUT_ready = !stA.valid || stA.tag[MSB] || IN_rfReadGrant.
- stA, register tag (MSB=0): OUT_rfReadValid=1, OUT_rfReadAddr=stA.tag[TAG_W-2:0]. Move to stB on grant; otherwise hold and re-request every cycle.
- stA, immediate tag: no request (OUT_rfReadValid=0); moves to stB unconditionally.
- stA also advances when it is invalid. A new uop and a departing stA may swap in the same cycle.
- stB never stalls: raw = immediate ? zero-extend(tag[TAG_W-2:0]) : IN_rfReadData.
- out.data = raw << (8*offs), truncated to XLEN. out.valid = stB.valid && !killed(stB).
- out is rewritten every cycle; valid drops when stB is empty.
- killed(x) = IN_branch.taken && (IN_branch.flush || $signed(x.storeSqN - IN_branch.storeSqN) > 0).
- On kill: clear the valid of stA and stB at the edge; do not accept a killed IN_uop.
- Entries at or older than the branch storeSqN survive and continue normally.
- A kill does not retract an out value registered on a previous edge; the store queue flushes its own entries.
- Ordering: single in-order pipe; uops reach OUT_sqWrite in acceptance order.

## Timing
- Reset: stA.valid=stB.valid=out.valid=0, OUT_rfReadValid=0, OUT_ready=1. Data fields are don't-care.
- Reset asserted mid-operation discards all in-flight uops immediately (asynchronous).
- Granted path: accept at edge N; request in cycle N..N+1; stB at edge N+1; OUT_sqWrite.valid from edge N+2 (2-cycle latency).
- Immediate path: same 2-cycle latency, independent of grant.
- Each denied grant cycle adds one cycle and holds OUT_ready=0.
- Throughput: one uop per cycle with a continuous grant.
- Branch and grant in the same cycle: kill wins; the stA entry is dropped, even though the RF read is already issued and its data is ignored.
- SqN wrap: only the signed difference is used. For SQN_W=6, 0x01 is younger than 0x3F.

## Test plan
- Back-to-back register tags 5, 6, 7 with offs 0, 1, 3, grant always 1, RF returns 0xAABBCCDD. Required: OUT_sqWrite at N+2, N+3, N+4 with data 0xAABBCCDD, 0xBBCCDD00, 0xDD000000 and matching storeSqN.
- Immediate tag 0x41, offs 0, grant held 0. Required: no RF request, OUT_ready=1, OUT_sqWrite.data=0x00000001 two cycles later.
- Register tag with grant denied for 3 cycles, then granted. Required: OUT_rfReadValid high 4 cycles with constant address; OUT_ready=0 for 3 cycles; data written 5 cycles after accept; a second uop is held upstream.
- stA storeSqN=0x12, stB storeSqN=0x10, branch taken with storeSqN=0x11, flush=0. Required: stB writes; stA is dropped; the next uop is accepted the following cycle.
- Wrap: in-flight storeSqN=0x01, branch storeSqN=0x3F. Required: killed. Then branch flush=1 with all stages full: every stage is cleared and no write occurs after the branch edge.
- Assert rst with all three stages valid. Required: out.valid and OUT_rfReadValid drop immediately; OUT_ready=1.
